// File: rtl/ps2_keyboard_receiver_if.sv
// rtl/ps2_keyboard_receiver_if.sv - decoded key event bus from the PS/2 receiver to the SoC keyboard port
// master drives the decoded scan code, strobes, modifier state and prefix debug flags.
interface ps2_keyboard_receiver_if;
  logic [7:0] code;
  logic       codeValid;
  logic       extended;
  logic       released;
  logic       frameError;
  logic       shiftDown;
  logic       ctrlDown;
  logic       altDown;
  logic       prefixE0;
  logic       prefixF0;

  modport master (
    output code, codeValid, extended, released, frameError,
    output shiftDown, ctrlDown, altDown, prefixE0, prefixF0
  );

  modport slave (
    input code, codeValid, extended, released, frameError,
    input shiftDown, ctrlDown, altDown, prefixE0, prefixF0
  );
endinterface

// File: rtl/ps2_keyboard_receiver.sv
// rtl/ps2_keyboard_receiver.sv - PS/2 keyboard frame deserialiser with E0/F0 prefix and modifier tracking
// Samples data on ps2Clk falling edges; aborts a partial frame after TIMEOUT_CYCLES without a fall.
module ps2_keyboard_receiver #(
  parameter int TIMEOUT_CYCLES = 16000
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2Clk,
  input  logic ps2Data,
  ps2_keyboard_receiver_if.master kbd
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state;
  logic          prevClk;
  logic [2:0]    bitCnt;
  logic [TW-1:0] timer;
  logic [7:0]    shiftReg;
  logic          parityBit;
  logic          shiftL, shiftR, ctrlL, ctrlR, altL, altR;
  logic          nShiftL, nShiftR, nCtrlL, nCtrlR, nAltL, nAltR;

  logic [7:0] codeR;
  logic       codeValidR, extendedR, releasedR, frameErrorR;
  logic       shiftDownR, ctrlDownR, altDownR, prefixE0R, prefixF0R;

  logic fall;
  logic frameOk;

  assign fall    = prevClk & ~ps2Clk;
  assign frameOk = ps2Data & (^{shiftReg, parityBit});

  // E0 12 / E0 59 are the keyboard's fake shifts and must not touch shift state.
  always_comb begin
    nShiftL = shiftL;
    nShiftR = shiftR;
    nCtrlL  = ctrlL;
    nCtrlR  = ctrlR;
    nAltL   = altL;
    nAltR   = altR;
    case (shiftReg)
      8'h12: if (!prefixE0R) nShiftL = ~prefixF0R;
      8'h59: if (!prefixE0R) nShiftR = ~prefixF0R;
      8'h14: if (prefixE0R) nCtrlR = ~prefixF0R; else nCtrlL = ~prefixF0R;
      8'h11: if (prefixE0R) nAltR = ~prefixF0R; else nAltL = ~prefixF0R;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      prevClk     <= 1'b1;
      bitCnt      <= '0;
      timer       <= '0;
      shiftReg    <= '0;
      parityBit   <= 1'b0;
      shiftL      <= 1'b0;
      shiftR      <= 1'b0;
      ctrlL       <= 1'b0;
      ctrlR       <= 1'b0;
      altL        <= 1'b0;
      altR        <= 1'b0;
      codeR       <= '0;
      codeValidR  <= 1'b0;
      extendedR   <= 1'b0;
      releasedR   <= 1'b0;
      frameErrorR <= 1'b0;
      shiftDownR  <= 1'b0;
      ctrlDownR   <= 1'b0;
      altDownR    <= 1'b0;
      prefixE0R   <= 1'b0;
      prefixF0R   <= 1'b0;
    end else begin
      prevClk     <= ps2Clk;
      codeValidR  <= 1'b0;
      frameErrorR <= 1'b0;
      if (state == IDLE) begin
        timer  <= '0;
        bitCnt <= '0;
        if (fall && !ps2Data) state <= DATA;
      end else if (fall) begin
        timer <= '0;
        case (state)
          DATA: begin
            shiftReg <= {ps2Data, shiftReg[7:1]};
            bitCnt   <= bitCnt + 3'd1;
            if (bitCnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            parityBit <= ps2Data;
            state     <= STOP;
          end
          default: begin
            state <= IDLE;
            if (!frameOk) begin
              frameErrorR <= 1'b1;
              prefixE0R   <= 1'b0;
              prefixF0R   <= 1'b0;
            end else if (shiftReg == 8'hE0) begin
              prefixE0R <= 1'b1;
            end else if (shiftReg == 8'hF0) begin
              prefixF0R <= 1'b1;
            end else begin
              codeR      <= shiftReg;
              extendedR  <= prefixE0R;
              releasedR  <= prefixF0R;
              codeValidR <= 1'b1;
              prefixE0R  <= 1'b0;
              prefixF0R  <= 1'b0;
              shiftL     <= nShiftL;
              shiftR     <= nShiftR;
              ctrlL      <= nCtrlL;
              ctrlR      <= nCtrlR;
              altL       <= nAltL;
              altR       <= nAltR;
              shiftDownR <= nShiftL | nShiftR;
              ctrlDownR  <= nCtrlL | nCtrlR;
              altDownR   <= nAltL | nAltR;
            end
          end
        endcase
      end else if (timer == TIMEOUT_LAST) begin
        state       <= IDLE;
        timer       <= '0;
        frameErrorR <= 1'b1;
        prefixE0R   <= 1'b0;
        prefixF0R   <= 1'b0;
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end

  assign kbd.code       = codeR;
  assign kbd.codeValid  = codeValidR;
  assign kbd.extended   = extendedR;
  assign kbd.released   = releasedR;
  assign kbd.frameError = frameErrorR;
  assign kbd.shiftDown  = shiftDownR;
  assign kbd.ctrlDown   = ctrlDownR;
  assign kbd.altDown    = altDownR;
  assign kbd.prefixE0   = prefixE0R;
  assign kbd.prefixF0   = prefixF0R;
endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// tb/tb_ps2_keyboard_receiver.sv - directed bench for ps2_keyboard_receiver
// Drives hand-built PS/2 frames and checks decoded codes, strobes, prefixes and modifiers.
module tb_ps2_keyboard_receiver;
  localparam int TO = 16000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ps2Clk = 1'b1;
  logic ps2Data = 1'b1;

  int checks = 0;
  int failures = 0;
  int cvCount = 0;
  int feCount = 0;
  int bothCount = 0;
  int cvBase, feBase;
  logic latCv, latFe;

  ps2_keyboard_receiver_if kbd ();

  ps2_keyboard_receiver #(.TIMEOUT_CYCLES(TO)) dut (
    .clk     (clk),
    .reset   (reset),
    .ps2Clk  (ps2Clk),
    .ps2Data (ps2Data),
    .kbd     (kbd)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (kbd.codeValid) cvCount++;
    if (kbd.frameError) feCount++;
    if (kbd.codeValid && kbd.frameError) bothCount++;
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sendBit(input logic b);
    @(negedge clk);
    ps2Data = b;
    repeat (3) @(negedge clk);
    ps2Clk = 1'b0;
    repeat (4) @(negedge clk);
    ps2Clk = 1'b1;
  endtask

  // Stop bit is sent inline so the strobe can be sampled in the cycle right after the fall.
  task automatic sendFrame(input logic [7:0] b, input logic badParity);
    logic par;
    par = (~^b) ^ badParity;
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(b[i]);
    sendBit(par);
    @(negedge clk);
    ps2Data = 1'b1;
    repeat (3) @(negedge clk);
    ps2Clk = 1'b0;
    @(negedge clk);
    latCv = kbd.codeValid;
    latFe = kbd.frameError;
    repeat (3) @(negedge clk);
    ps2Clk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic frameCheck(input string tag, input logic [7:0] b, input logic badParity,
                            input int expCv, input int expFe);
    cvBase = cvCount;
    feBase = feCount;
    sendFrame(b, badParity);
    checkVal({tag, "_cvCount"}, 32'(cvCount - cvBase), 32'(expCv));
    checkVal({tag, "_feCount"}, 32'(feCount - feBase), 32'(expFe));
    if (expCv != 0) checkVal({tag, "_cvLatency"}, 32'(latCv), 32'd1);
    if (expFe != 0) checkVal({tag, "_feLatency"}, 32'(latFe), 32'd1);
  endtask

  function automatic logic [31:0] allOut();
    return {15'd0, kbd.code, kbd.codeValid, kbd.extended, kbd.released, kbd.frameError,
            kbd.shiftDown, kbd.ctrlDown, kbd.altDown, kbd.prefixE0, kbd.prefixF0};
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    checkVal("reset_outputs", allOut(), 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Idle fall with data high is not a start bit.
    cvBase = cvCount;
    feBase = feCount;
    sendBit(1'b1);
    repeat (4) @(negedge clk);
    checkVal("idle_fall_fe", 32'(feCount - feBase), 32'd0);
    checkVal("idle_fall_cv", 32'(cvCount - cvBase), 32'd0);

    frameCheck("t1_1c", 8'h1C, 1'b0, 1, 0);
    checkVal("t1_code", 32'(kbd.code), 32'h1C);
    checkVal("t1_ext", 32'(kbd.extended), 32'd0);
    checkVal("t1_rel", 32'(kbd.released), 32'd0);

    frameCheck("t2_f0", 8'hF0, 1'b0, 0, 0);
    checkVal("t2_prefixF0_set", 32'(kbd.prefixF0), 32'd1);
    frameCheck("t2_1c", 8'h1C, 1'b0, 1, 0);
    checkVal("t2_code", 32'(kbd.code), 32'h1C);
    checkVal("t2_rel", 32'(kbd.released), 32'd1);
    checkVal("t2_prefixF0_clr", 32'(kbd.prefixF0), 32'd0);

    frameCheck("t3_12", 8'h12, 1'b0, 1, 0);
    checkVal("t3_shift_a", 32'(kbd.shiftDown), 32'd1);
    frameCheck("t3_59", 8'h59, 1'b0, 1, 0);
    checkVal("t3_shift_b", 32'(kbd.shiftDown), 32'd1);
    sendFrame(8'hF0, 1'b0);
    frameCheck("t3_f0_12", 8'h12, 1'b0, 1, 0);
    checkVal("t3_shift_c", 32'(kbd.shiftDown), 32'd1);
    sendFrame(8'hF0, 1'b0);
    frameCheck("t3_f0_59", 8'h59, 1'b0, 1, 0);
    checkVal("t3_shift_d", 32'(kbd.shiftDown), 32'd0);

    sendFrame(8'hE0, 1'b0);
    checkVal("t3_prefixE0", 32'(kbd.prefixE0), 32'd1);
    frameCheck("t3_e0_14", 8'h14, 1'b0, 1, 0);
    checkVal("t3_ctrl_a", 32'(kbd.ctrlDown), 32'd1);
    checkVal("t3_ext_a", 32'(kbd.extended), 32'd1);
    sendFrame(8'hE0, 1'b0);
    sendFrame(8'hF0, 1'b0);
    frameCheck("t3_e0f0_14", 8'h14, 1'b0, 1, 0);
    checkVal("t3_ctrl_b", 32'(kbd.ctrlDown), 32'd0);
    checkVal("t3_ext_b", 32'(kbd.extended), 32'd1);
    checkVal("t3_rel_b", 32'(kbd.released), 32'd1);

    sendFrame(8'h12, 1'b0);
    sendFrame(8'hE0, 1'b0);
    sendFrame(8'hF0, 1'b0);
    frameCheck("t3_fake_rel", 8'h12, 1'b0, 1, 0);
    checkVal("t3_fake_shift_held", 32'(kbd.shiftDown), 32'd1);
    sendFrame(8'hF0, 1'b0);
    sendFrame(8'h12, 1'b0);
    sendFrame(8'hE0, 1'b0);
    frameCheck("t3_fake_make", 8'h12, 1'b0, 1, 0);
    checkVal("t3_fake_shift_up", 32'(kbd.shiftDown), 32'd0);

    sendFrame(8'h11, 1'b0);
    checkVal("t3_alt_a", 32'(kbd.altDown), 32'd1);
    sendFrame(8'hE0, 1'b0);
    sendFrame(8'hF0, 1'b0);
    sendFrame(8'h11, 1'b0);
    checkVal("t3_alt_b", 32'(kbd.altDown), 32'd1);
    sendFrame(8'hF0, 1'b0);
    sendFrame(8'h11, 1'b0);
    checkVal("t3_alt_c", 32'(kbd.altDown), 32'd0);

    sendFrame(8'hF0, 1'b0);
    frameCheck("t4_badpar", 8'h1C, 1'b1, 0, 1);
    checkVal("t4_prefixF0", 32'(kbd.prefixF0), 32'd0);
    frameCheck("t4_good", 8'h1C, 1'b0, 1, 0);
    checkVal("t4_rel", 32'(kbd.released), 32'd0);

    cvBase = cvCount;
    feBase = feCount;
    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b0);
    sendBit(1'b1);
    repeat (TO + 20) @(negedge clk);
    checkVal("t5_timeout_fe", 32'(feCount - feBase), 32'd1);
    checkVal("t5_timeout_cv", 32'(cvCount - cvBase), 32'd0);
    frameCheck("t5_after", 8'h1C, 1'b0, 1, 0);
    checkVal("t5_code", 32'(kbd.code), 32'h1C);

    sendFrame(8'h59, 1'b0);
    checkVal("t6_shift_before", 32'(kbd.shiftDown), 32'd1);
    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 checkVal("t6_async_reset", allOut(), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    frameCheck("t6_after", 8'h1C, 1'b0, 1, 0);
    checkVal("t6_code", 32'(kbd.code), 32'h1C);
    checkVal("t6_shift_after", 32'(kbd.shiftDown), 32'd0);

    checkVal("never_both_strobes", 32'(bothCount), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
